ha_9: RTL and testbench

HA_9 -- requirements
Module: ha_9

---
 rtl/ha_9.sv | 113 +++++++++++
 tb/tb_ha_9.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_9.sv
// ha_9: half adder with inertial rise/fall-delayed outputs, registered sum/carry and an optional
// saturating carry-event counter, built only when HA_9_CARRY_CNT_EN is defined.
`timescale 1ns / 1ps

module ha_9 #(
    parameter int unsigned TRISE = 1,
    parameter int unsigned TFALL = 2,
    parameter int unsigned CNT_W = 8
) (
    output logic             s,
    output logic             ca,
    input  logic             a,
    input  logic             b,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_clr,
    output logic             s_q,
    output logic             ca_q,
    output logic [CNT_W-1:0] carry_cnt
);

    logic sum_w;
    logic car_w;

    assign sum_w = a ^ b;
    assign car_w = a & b;

`ifdef SYNTHESIS
    assign s  = sum_w;
    assign ca = car_w;
`else
    localparam time DlyRise = time'(TRISE);
    localparam time DlyFall = time'(TFALL);

    // Inertial path model: each input edge re-arms the path with a fresh due time, and only the
    // wake-up matching the latest due time may drive the output, so short pulses are swallowed.
    time  s_due;
    time  s_wake;
    logic s_tgt;
    time  ca_due;
    time  ca_wake;
    logic ca_tgt;

    always @(posedge sum_w or negedge sum_w) begin
        s_tgt  <= sum_w;
        s_due  <= $time + (sum_w ? DlyRise : DlyFall);
        s_wake <= #(sum_w ? DlyRise : DlyFall) $time + (sum_w ? DlyRise : DlyFall);
    end

    always @(s_wake) begin
        if (s_wake == s_due) begin
            s = s_tgt;
        end
    end

    always @(posedge car_w or negedge car_w) begin
        ca_tgt  <= car_w;
        ca_due  <= $time + (car_w ? DlyRise : DlyFall);
        ca_wake <= #(car_w ? DlyRise : DlyFall) $time + (car_w ? DlyRise : DlyFall);
    end

    always @(ca_wake) begin
        if (ca_wake == ca_due) begin
            ca = ca_tgt;
        end
    end
`endif

    // Registered copies take the undelayed sum and carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= 1'b0;
            ca_q <= 1'b0;
        end else begin
            s_q  <= sum_w;
            ca_q <= car_w;
        end
    end

`ifdef HA_9_CARRY_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             carry_evt;

    // An event is a 0->1 step of ca_q; a held carry counts once.
    assign carry_evt = ~ca_q & car_w;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (carry_evt && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign carry_cnt      = '0;
`endif

endmodule

// File: tb/tb_ha_9.sv
// Self-checking bench for ha_9: output path delays, inertial filtering, and randomized
// clocked traffic compared against a behavioural model of the sum/carry/counter rules.
`timescale 1ns / 1ps

module tb_ha_9;

    localparam int unsigned CntW   = 2;
    localparam int          CntMax = (1 << CntW) - 1;
`ifdef HA_9_CARRY_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    localparam logic [1:0] AbSeq  [5] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
    localparam logic [1:0] ScaExp [5] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b00};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a;
    logic            b;
    logic            cnt_clr;
    logic            s;
    logic            ca;
    logic            s_q;
    logic            ca_q;
    logic [CntW-1:0] carry_cnt;

    logic            a2;
    logic            b2;
    logic            s2;
    logic            unused_ca2;
    logic            unused_s_q2;
    logic            unused_ca_q2;
    logic [7:0]      unused_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic m_s_q;
    logic m_ca_q;
    int   m_cnt;

    ha_9 #(
        .TRISE(1),
        .TFALL(2),
        .CNT_W(CntW)
    ) u_dut (
        .s        (s),
        .ca       (ca),
        .a        (a),
        .b        (b),
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_clr  (cnt_clr),
        .s_q      (s_q),
        .ca_q     (ca_q),
        .carry_cnt(carry_cnt)
    );

    ha_9 #(
        .TRISE(2),
        .TFALL(2),
        .CNT_W(8)
    ) u_dut_slow (
        .s        (s2),
        .ca       (unused_ca2),
        .a        (a2),
        .b        (b2),
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_clr  (cnt_clr),
        .s_q      (unused_s_q2),
        .ca_q     (unused_ca_q2),
        .carry_cnt(unused_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural rules applied at a rising clock edge.
    task automatic model_edge(input logic na, input logic nb, input logic nclr);
        if (rst_n) begin
            if (CntEn) begin
                if (nclr) begin
                    m_cnt = 0;
                end else if (!m_ca_q && (na & nb) && (m_cnt < CntMax)) begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_s_q  = na ^ nb;
            m_ca_q = na & nb;
        end
    endtask

    // Starts and ends on a falling clock edge.
    task automatic drive_cycle(input logic na, input logic nb, input logic nclr);
        a       = na;
        b       = nb;
        cnt_clr = nclr;
        @(posedge clk);
        model_edge(na, nb, nclr);
        @(negedge clk);
        check_eq("s_q", s_q, m_s_q);
        check_eq("ca_q", ca_q, m_ca_q);
        check_eq("carry_cnt", carry_cnt, m_cnt);
        check_eq("s_comb", s, na ^ nb);
        check_eq("ca_comb", ca, na & nb);
    endtask

    // Asserts reset between edges; held across the next rising edge, released on a falling edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_s_q", s_q, 0);
        check_eq("rst_ca_q", ca_q, 0);
        check_eq("rst_cnt", carry_cnt, 0);
        check_eq("rst_ca_comb", ca, a & b);
        m_s_q  = 1'b0;
        m_ca_q = 1'b0;
        m_cnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] prev;

        rst_n   = 1'b0;
        a       = 1'b0;
        b       = 1'b0;
        cnt_clr = 1'b0;
        a2      = 1'b0;
        b2      = 1'b0;
        m_s_q   = 1'b0;
        m_ca_q  = 1'b0;
        m_cnt   = 0;
        prev    = 2'b00;

        // Rise/fall delays on the fast instance, one input step every 5 units.
        for (int i = 0; i < 5; i++) begin
            {a, b} = AbSeq[i];
            #0.5;
            check_eq("dly_before", {s, ca}, prev);
            #1;
            check_eq("dly_rise", {s, ca}, prev | ScaExp[i]);
            #1;
            check_eq("dly_fall", {s, ca}, ScaExp[i]);
            #2.5;
            prev = ScaExp[i];
        end

        // Inertial filtering on the slow instance: a 1-unit pulse must vanish.
        a2 = 1'b1;
        #0.5;
        check_eq("pulse_t0", s2, 0);
        #0.5;
        a2 = 1'b0;
        #1.5;
        check_eq("pulse_t1", s2, 0);
        #1;
        check_eq("pulse_t2", s2, 0);
        #1;
        check_eq("pulse_t3", s2, 0);
        #0.5;
        a2 = 1'b1;
        #1.5;
        check_eq("slow_rise_early", s2, 0);
        #1;
        check_eq("slow_rise", s2, 1);
        #0.5;
        a2 = 1'b0;
        #1.5;
        check_eq("slow_fall_early", s2, 1);
        #1;
        check_eq("slow_fall", s2, 0);

        // Held in reset while clocking with a carry present.
        @(negedge clk);
        a = 1'b1;
        b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("hold_rst_s_q", s_q, 0);
        check_eq("hold_rst_ca_q", ca_q, 0);
        check_eq("hold_rst_cnt", carry_cnt, 0);
        check_eq("hold_rst_ca", ca, 1);
        rst_n = 1'b1;

        // First edge after reset counts a carry; held carry counts once.
        drive_cycle(1'b1, 1'b1, 1'b0);
        check_eq("first_edge_cnt", carry_cnt, CntEn ? 1 : 0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        check_eq("hold_twice_cnt", carry_cnt, CntEn ? 2 : 0);

        // Saturation at 3 for a 2-bit counter, then clear beats a coincident event.
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            drive_cycle(1'b0, 1'b0, 1'b0);
        end
        check_eq("saturate_cnt", carry_cnt, CntEn ? 3 : 0);
        drive_cycle(1'b1, 1'b1, 1'b1);
        check_eq("clr_wins_cnt", carry_cnt, 0);

        // Mid-operation reset with a = b = 1.
        drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        async_reset();

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset();
            end else begin
                drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
